// File: rtl/popcount_arbiter.sv
// Round-robin arbiter that time-shares one external popcount pipeline among N_REQ
// requesters. Each grant is tagged with its requester id; the tag travels down a
// shadow pipeline that lines up with the counter's result and steers the response.
module popcount_arbiter #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned CNT_LATENCY = 3,
  localparam int unsigned CNT_W      = $clog2(WIDTH + 1),
  localparam int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   enable_i,
  input  logic [N_REQ-1:0]       req_mask_i,
  input  logic [N_REQ-1:0]       req_val_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       cnt_data_o,
  output logic                   cnt_data_val_o,
  input  logic [CNT_W-1:0]       cnt_data_i,
  input  logic                   cnt_data_val_i,
  output logic [CNT_W-1:0]       resp_data_o,
  output logic [N_REQ-1:0]       resp_val_o,
  output logic                   err_o
);

  localparam int unsigned DRAIN_W = $clog2(CNT_LATENCY + 1);

  logic [N_REQ-1:0]       eligible;
  logic                   gnt_found;
  logic [ID_W-1:0]        gnt_id;
  logic [ID_W-1:0]        rr_idx;
  logic [ID_W-1:0]        last_grant_q;

  logic [WIDTH-1:0]       cnt_data_q;
  logic                   cnt_val_q;
  logic [ID_W-1:0]        cnt_id_q;

  logic [CNT_LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]        tag_id_q [CNT_LATENCY];
  logic                   tag_v_last;
  logic [ID_W-1:0]        tag_id_last;

  // Counts down the cycles after reset in which results of discarded requests may
  // still emerge from the shared pipeline; those are dropped without an error.
  logic [DRAIN_W-1:0]     drain_q;

  logic                   rsp_hit;
  logic                   tag_mismatch;
  logic [N_REQ-1:0]       resp_val_d;
  logic [N_REQ-1:0]       resp_val_q;
  logic [CNT_W-1:0]       resp_data_q;
  logic                   err_q;

  // Round-robin search starting just after the last winner; first eligible wins.
  always_comb begin
    eligible    = req_val_i & req_mask_i & {N_REQ{enable_i & ~srst_i}};
    gnt_found   = 1'b0;
    gnt_id      = '0;
    rr_idx      = last_grant_q;
    req_ready_o = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      rr_idx = (rr_idx == ID_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
      if (!gnt_found && eligible[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_idx;
      end
    end
    req_ready_o[gnt_id] = gnt_found;
  end

  // Register the winner's data and id toward the shared counter; remember the winner.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      cnt_val_q    <= 1'b0;
      cnt_data_q   <= '0;
      cnt_id_q     <= '0;
    end else begin
      // A grant is only ever offered to a valid requester, so a grant is a handshake.
      cnt_val_q <= gnt_found;
      if (gnt_found) begin
        last_grant_q <= gnt_id;
        cnt_data_q   <= req_data_i[gnt_id * WIDTH +: WIDTH];
        cnt_id_q     <= gnt_id;
      end
    end
  end

  // Tag shadow pipeline, fed alongside cnt_data_val_o so its tail meets the result.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tag_v_q <= '0;
      for (int i = 0; i < int'(CNT_LATENCY); i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= cnt_val_q;
      tag_id_q[0] <= cnt_id_q;
      for (int i = 1; i < int'(CNT_LATENCY); i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  // Post-reset window in which untagged results are silently dropped.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      drain_q <= DRAIN_W'(CNT_LATENCY);
    end else if (drain_q != '0) begin
      drain_q <= drain_q - 1'b1;
    end
  end

  // Match the returning result against the tail tag and decode the owner.
  always_comb begin
    tag_v_last   = tag_v_q[CNT_LATENCY-1];
    tag_id_last  = tag_id_q[CNT_LATENCY-1];
    rsp_hit      = cnt_data_val_i & tag_v_last;
    tag_mismatch = (cnt_data_val_i != tag_v_last) & (drain_q == '0);
    resp_val_d   = '0;
    if (rsp_hit) begin
      resp_val_d[tag_id_last] = 1'b1;
    end
  end

  // Response register and sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      resp_val_q  <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      resp_val_q <= resp_val_d;
      if (rsp_hit) begin
        resp_data_q <= cnt_data_i;
      end
      if (tag_mismatch) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cnt_data_o     = cnt_data_q;
  assign cnt_data_val_o = cnt_val_q;
  assign resp_data_o    = resp_data_q;
  assign resp_val_o     = resp_val_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Randomised bench for popcount_arbiter with a behavioural shared-counter model
// and a transaction-level reference model of arbitration and responses.
module tb_popcount_arbiter;

  localparam int W  = 24;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           srst;
  logic           enable;
  logic [N-1:0]   mask;
  logic [N-1:0]   val;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic [W-1:0]   cnt_data;
  logic           cnt_val;
  logic [CW-1:0]  cnt_res;
  logic           cnt_res_val;
  logic [CW-1:0]  resp_data;
  logic [N-1:0]   resp_val;
  logic           err;

  popcount_arbiter #(
    .WIDTH       (W),
    .N_REQ       (N),
    .CNT_LATENCY (L)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .enable_i       (enable),
    .req_mask_i     (mask),
    .req_val_i      (val),
    .req_data_i     (data),
    .req_ready_o    (ready),
    .cnt_data_o     (cnt_data),
    .cnt_data_val_o (cnt_val),
    .cnt_data_i     (cnt_res),
    .cnt_data_val_i (cnt_res_val),
    .resp_data_o    (resp_data),
    .resp_val_o     (resp_val),
    .err_o          (err)
  );

  // External shared popcount pipeline: L cycles, never reset by the arbiter.
  logic [L-1:0]  pv = '0;
  logic [CW-1:0] pd [L];
  logic          inject;
  logic [CW-1:0] inject_data;

  always @(posedge clk) begin
    pv    <= {pv[L-2:0], cnt_val === 1'b1};
    pd[0] <= CW'($countones(cnt_data));
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end

  assign cnt_res_val = pv[L-1] | inject;
  assign cnt_res     = inject ? inject_data : pd[L-1];

  // Reference model state
  typedef struct {
    int due;
    int id;
    int cnt;
  } rsp_t;

  rsp_t         pend[$];
  int           lg;
  int           cyc;
  int           n_vec;
  int           n_miss;
  logic         m_cval;
  logic [W-1:0] m_cdata;
  int           m_rdata;
  logic         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    lg      = N - 1;
    m_cval  = 1'b0;
    m_cdata = '0;
    m_rdata = 0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model.
  task automatic step();
    int           gid;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W-1:0] d;
    @(negedge clk);
    gid = -1;
    if (!srst && enable) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (lg + i) % N;
        if (gid < 0 && val[k] && mask[k]) gid = k;
      end
    end
    exp_ready = '0;
    if (gid >= 0) exp_ready[gid] = 1'b1;
    check_eq("ready", 32'(ready), 32'(exp_ready));
    check_eq("cnt_val", 32'(cnt_val), 32'(m_cval));
    check_eq("cnt_data", 32'(cnt_data), 32'(m_cdata));
    exp_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].id] = 1'b1;
      m_rdata = pend[0].cnt;
      void'(pend.pop_front());
    end
    check_eq("resp_val", 32'(resp_val), 32'(exp_rv));
    check_eq("resp_data", 32'(resp_data), m_rdata);
    check_eq("err", 32'(err), 32'(m_err));
    if (srst) begin
      model_reset();
    end else begin
      m_cval = (gid >= 0);
      if (gid >= 0) begin
        d       = data[gid*W +: W];
        m_cdata = d;
        pend.push_back('{cyc + L + 2, gid, $countones(d)});
        lg = gid;
      end
      if (inject) m_err = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
  endtask

  initial begin
    srst        = 1'b1;
    enable      = 1'b0;
    mask        = '0;
    val         = '0;
    data        = '0;
    inject      = 1'b0;
    inject_data = 5'd7;
    n_vec       = 0;
    n_miss      = 0;
    cyc         = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state held for a few cycles
    repeat (3) step();
    srst = 1'b0;

    // Single request from requester 2
    enable = 1'b1;
    mask   = '1;
    val    = 4'b0100;
    data[2*W +: W] = 24'hFF00F0;
    step();
    val = '0;
    repeat (7) step();

    // Round-robin with all requesters continuously valid
    val = '1;
    repeat (12) begin
      rand_data();
      step();
    end
    val = '0;
    repeat (6) step();

    // Masked requesters, then global enable dropped with traffic in flight
    mask = 4'b1010;
    val  = '1;
    repeat (8) begin
      rand_data();
      step();
    end
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (4) begin
      rand_data();
      step();
    end
    val  = '0;
    mask = '1;
    repeat (6) step();

    // Boundary data values
    val = 4'b0001;
    data[0*W +: W] = 24'h000000;
    step();
    val = 4'b1000;
    data[3*W +: W] = 24'hFFFFFF;
    step();
    val = '0;
    repeat (6) step();

    // Random traffic
    repeat (300) begin
      enable = ($urandom_range(0, 7) != 0);
      mask   = N'($urandom);
      val    = N'($urandom);
      rand_data();
      step();
    end
    val    = '0;
    enable = 1'b1;
    mask   = '1;
    repeat (8) step();

    // Reset with three requests in flight
    val = '1;
    repeat (3) begin
      rand_data();
      step();
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    repeat (8) begin
      rand_data();
      step();
    end
    val = '0;
    repeat (10) step();

    // Spurious result with nothing in flight
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (5) step();
    srst = 1'b1;
    repeat (2) step();
    srst = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/popcount_arbiter.md
POPCOUNT_ARBITER -- requirements
Module: popcount_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 24, the request data width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, the number of requesters (2..16).
REQ-003 SHALL have parameter CNT_LATENCY, default 3, the shared counter latency in cycles from input valid to output valid (1..8).
REQ-004 SHALL define local CNT_W = $clog2(WIDTH+1) and ID_W = $clog2(N_REQ).
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port srst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable_i  input  1  global grant enable.
REQ-008 SHALL have port req_mask_i  input  N_REQ  per-requester grant enable (1 = eligible).
REQ-009 SHALL have port req_val_i  input  N_REQ  request valid per requester.
REQ-010 SHALL have port req_data_i  input  N_REQ x WIDTH  request data, packed, requester k at [k*WIDTH +: WIDTH].
REQ-011 SHALL have port req_ready_o  output  N_REQ  one-hot grant/ready.
REQ-012 SHALL have port cnt_data_o  output  WIDTH  data to the shared popcount pipeline.
REQ-013 SHALL have port cnt_data_val_o  output  1  valid to the shared pipeline.
REQ-014 SHALL have port cnt_data_i  input  CNT_W  result from the shared pipeline.
REQ-015 SHALL have port cnt_data_val_i  input  1  result valid from the shared pipeline.
REQ-016 SHALL have port resp_data_o  output  CNT_W  result, broadcast to all requesters.
REQ-017 SHALL have port resp_val_o  output  N_REQ  one-hot result valid, bit k = result belongs to requester k.
REQ-018 SHALL have port err_o  output  1  sticky protocol error.

Function
REQ-019 Eligible requester: req_val_i[k] & req_mask_i[k] & enable_i.
REQ-020 Arbitration: round-robin; search starts at last_grant+1 modulo N_REQ; first eligible requester wins; at most one grant per cycle.
REQ-021 req_ready_o SHALL be combinational from eligibility and last_grant; req_ready_o = 0 when no eligible requester or enable_i = 0.
REQ-022 Handshake at cycle T (req_val_i[k] & req_ready_o[k]) SHALL update last_grant to k at the end of T.
REQ-023 The granted data SHALL be registered: cnt_data_o = req_data_i[k] sampled at T, cnt_data_val_o = 1 during T+1; cnt_data_val_o = 0 in any cycle after a cycle with no grant.
REQ-024 cnt_data_o SHALL hold its last value when cnt_data_val_o = 0.
REQ-025 A tag pipeline of CNT_LATENCY stages (valid bit + ID_W-bit id) SHALL advance every cycle, entered in parallel with cnt_data_val_o.
REQ-026 When cnt_data_val_i = 1 and the tag at the last stage is valid, resp_data_o SHALL be registered from cnt_data_i and resp_val_o[id] = 1 one cycle later; total latency = CNT_LATENCY + 2 cycles after the handshake.
REQ-027 resp_val_o SHALL be a single-cycle pulse per result with no backpressure; back-to-back results SHALL produce back-to-back pulses.
REQ-028 resp_data_o SHALL hold its last value when resp_val_o = 0.
REQ-029 Mismatch (cnt_data_val_i differs from last-stage tag valid) SHALL set err_o = 1 until reset; no response SHALL be emitted for a mismatched cycle.
REQ-030 Deasserting enable_i or req_mask_i SHALL block new grants only; in-flight requests SHALL complete and respond normally.
REQ-031 Throughput SHALL be one request per cycle with continuous requests.

Reset
REQ-032 While srst_i = 1: req_ready_o = 0, cnt_data_val_o = 0, resp_val_o = 0, err_o = 0, cnt_data_o = 0, resp_data_o = 0, all tag stages invalid, last_grant = N_REQ-1 (requester 0 has first priority).
REQ-033 Reset mid-operation SHALL discard all in-flight tags; results arriving from the pipeline after reset are untagged: if cnt_data_val_i = 1 within CNT_LATENCY cycles after reset, err_o SHALL NOT be set; results are dropped.
REQ-034 The first grant SHALL be possible in the cycle after srst_i deasserts.

Verification
REQ-035 Single: req 2 valid, data 24'hFF00F0 -> ready[2] at T; cnt_data_val_o at T+1; with model result 12, resp_val_o = 4'b0100 and resp_data_o = 12 at T+5.
REQ-036 Round-robin: all 4 valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; resp_val_o sequence 0001,0010,0100,1000 back-to-back.
REQ-037 Mask/enable: req_mask_i = 4'b1010, all valid -> grants alternate 1,3; enable_i = 0 for 3 cycles -> no grants, in-flight responses still delivered.
REQ-038 Boundary data: 24'h000000 -> 0; 24'hFFFFFF -> 24 (CNT_W = 5 bits, no truncation).
REQ-039 Error: inject cnt_data_val_i = 1 with no request in flight -> err_o = 1 next cycle, no resp_val_o, err_o stays 1 until srst_i.
REQ-040 Reset mid-stream: srst_i for one cycle with 3 requests in flight -> no resp_val_o for those; err_o remains 0; next grant goes to requester 0.
